rle_window_gen: RTL and testbench

//  Upstream stage of the RLECCA labeller: turns a raster binary pixel stream into the per-column
//  2x2 neighbourhood (A,B prev row; r2,r1 current row) plus run bbox/extra data the table reader consumes.

---
 rtl/rle_window_gen.sv | 179 +++++++++++++++++
 tb/tb_rle_window_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rle_window_gen.sv
// Raster-to-2x2-window front end for the RLE labeller: keeps the previous row in a 1-bit
// line buffer, tracks the current foreground run and appends a flush column and flush row.
module rle_window_gen #(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int x_bit     = 10,
  parameter int y_bit     = 9,
  parameter int data_bit  = 2 * x_bit + 2 * y_bit,
  parameter int extra_bit = 19
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 pix_valid_i,
  input  logic                 pix_i,
  output logic                 pix_ready_o,
  output logic                 datavalid_o,
  output logic                 A_o,
  output logic                 B_o,
  output logic                 r1_o,
  output logic                 r2_o,
  output logic [x_bit-1:0]     x_o,
  output logic [y_bit-1:0]     y_o,
  output logic [data_bit-1:0]  d_o,
  output logic [extra_bit-1:0] e_o,
  output logic                 eol_o,
  output logic                 eof_o
);

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [x_bit-1:0] XLAST = x_bit'(IMG_W - 1);
  localparam logic [x_bit-1:0] XFLUSH = x_bit'(IMG_W);
  localparam logic [y_bit-1:0] YLAST = y_bit'(IMG_H - 1);
  localparam logic [y_bit-1:0] YFLUSH = y_bit'(IMG_H);
  localparam logic [data_bit-1:0] INIT_BBOX =
    {{x_bit{1'b1}}, {x_bit{1'b0}}, {y_bit{1'b1}}, {y_bit{1'b0}}};
  localparam logic [extra_bit-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {ST_ROW, ST_COLF, ST_FRMF} state_t;

  state_t state_q, state_d;
  logic [x_bit-1:0] cx_q, cx_d;
  logic [y_bit-1:0] cy_q, cy_d;
  logic line_mem [IMG_W];

  logic dv_q, a_q, b_q, r1_q, r2_q, eol_q, eof_q;
  logic [x_bit-1:0] x_q;
  logic [y_bit-1:0] y_q;
  logic [data_bit-1:0] d_q;
  logic [extra_bit-1:0] e_q;

  logic emit, wr_en, b_raw;
  logic a_d, b_d, r1_d, r2_d, eol_d, eof_d;
  logic [x_bit-1:0] x0_d;
  logic [extra_bit-1:0] cnt_d;
  logic [data_bit-1:0] d_d;
  logic [extra_bit-1:0] e_d;

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    emit    = 1'b0;
    wr_en   = 1'b0;
    b_raw   = line_mem[cx_q[AW-1:0]];
    b_d     = 1'b0;
    r1_d    = 1'b0;
    eol_d   = 1'b0;
    eof_d   = 1'b0;
    case (state_q)
      ST_ROW: begin
        if (pix_valid_i) begin
          emit  = 1'b1;
          wr_en = 1'b1;
          r1_d  = pix_i;
          b_d   = (cy_q != '0) & b_raw;
          if (cx_q == XLAST) begin
            cx_d    = XFLUSH;
            state_d = ST_COLF;
          end else begin
            cx_d = cx_q + 1'b1;
          end
        end
      end
      ST_COLF: begin
        emit  = 1'b1;
        eol_d = 1'b1;
        cx_d  = '0;
        if (cy_q < YLAST) begin
          cy_d    = cy_q + 1'b1;
          state_d = ST_ROW;
        end else begin
          cy_d    = YFLUSH;
          state_d = ST_FRMF;
        end
      end
      ST_FRMF: begin
        emit = 1'b1;
        b_d  = (cx_q != XFLUSH) & b_raw;
        if (cx_q == XFLUSH) begin
          eol_d   = 1'b1;
          eof_d   = 1'b1;
          cx_d    = '0;
          cy_d    = '0;
          state_d = ST_ROW;
        end else begin
          cx_d = cx_q + 1'b1;
        end
      end
      default: state_d = ST_ROW;
    endcase

    // The last emitted column is always x-1 of the same row whenever x > 0.
    a_d  = (cx_q != '0) & (cy_q != '0) & b_q;
    r2_d = (cx_q != '0) & (state_q != ST_FRMF) & r1_q;

    x0_d  = cx_q;
    cnt_d = {{(extra_bit-1){1'b0}}, 1'b1};
    if (r1_d && r2_d) begin
      x0_d  = d_q[data_bit-1 -: x_bit];
      cnt_d = (e_q == CNT_MAX) ? e_q : e_q + 1'b1;
    end
    d_d = r1_d ? {x0_d, cx_q, cy_q, cy_q} : INIT_BBOX;
    e_d = r1_d ? cnt_d : '0;
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) line_mem[cx_q[AW-1:0]] <= pix_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_ROW;
      cx_q    <= '0;
      cy_q    <= '0;
      dv_q    <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      r1_q    <= 1'b0;
      r2_q    <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      d_q     <= INIT_BBOX;
      e_q     <= '0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      dv_q    <= emit;
      if (emit) begin
        a_q   <= a_d;
        b_q   <= b_d;
        r1_q  <= r1_d;
        r2_q  <= r2_d;
        eol_q <= eol_d;
        eof_q <= eof_d;
        x_q   <= cx_q;
        y_q   <= cy_q;
        d_q   <= d_d;
        e_q   <= e_d;
      end
    end
  end

  assign pix_ready_o = (state_q == ST_ROW);
  assign datavalid_o = dv_q;
  assign A_o         = a_q;
  assign B_o         = b_q;
  assign r1_o        = r1_q;
  assign r2_o        = r2_q;
  assign x_o         = x_q;
  assign y_o         = y_q;
  assign d_o         = d_q;
  assign e_o         = e_q;
  assign eol_o       = eol_q;
  assign eof_o       = eof_q;

endmodule

// File: tb/tb_rle_window_gen.sv
// Bench for rle_window_gen on an 8x4 image: frame-level window/run model plus literal pins.
module tb_rle_window_gen;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int XB = 4;
  localparam int YB = 3;
  localparam int DB = 2 * XB + 2 * YB;
  localparam int EB = 3;
  localparam logic [DB-1:0] INIT = {4'hF, 4'h0, 3'h7, 3'h0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_valid = 1'b0;
  logic pix = 1'b0;
  logic pix_ready, datavalid, A, B, r1, r2, eol, eof;
  logic [XB-1:0] x;
  logic [YB-1:0] y;
  logic [DB-1:0] d;
  logic [EB-1:0] e;

  always #5 clk = ~clk;

  rle_window_gen #(.IMG_W(W), .IMG_H(H), .x_bit(XB), .y_bit(YB), .data_bit(DB), .extra_bit(EB)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .pix_valid_i(pix_valid), .pix_i(pix), .pix_ready_o(pix_ready),
    .datavalid_o(datavalid), .A_o(A), .B_o(B), .r1_o(r1), .r2_o(r2), .x_o(x), .y_o(y),
    .d_o(d), .e_o(e), .eol_o(eol), .eof_o(eof)
  );

  typedef struct packed {
    logic a, b, r1, r2, eol, eof;
    logic [XB-1:0] x;
    logic [YB-1:0] y;
    logic [DB-1:0] d;
    logic [EB-1:0] e;
  } exp_t;

  int checks = 0;
  int failures = 0;
  bit img [H][W];
  exp_t expq [$];
  exp_t last;
  int n_dv, n_eol, n_eof;
  logic [DB-1:0] cap_d [H+1][W+1];
  logic [EB-1:0] cap_e [H+1][W+1];
  logic cap_a [H+1][W+1];
  logic cap_b [H+1][W+1];
  logic cap_r1 [H+1][W+1];
  logic cap_r2 [H+1][W+1];
  logic cap_eol [H+1][W+1];
  logic cap_eof [H+1][W+1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic bit pix_at(input int px, input int py);
    if (px < 0 || px >= W || py < 0 || py >= H) return 1'b0;
    return img[py][px];
  endfunction

  task automatic set_img(input logic [W-1:0] r0, input logic [W-1:0] r1v,
                         input logic [W-1:0] r2v, input logic [W-1:0] r3v);
    logic [W-1:0] rows [H];
    rows[0] = r0; rows[1] = r1v; rows[2] = r2v; rows[3] = r3v;
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++) img[yy][xx] = rows[yy][W-1-xx];
  endtask

  // Expected stream: every pixel outside the image reads as 0, which covers all masking rules.
  task automatic build_exp();
    exp_t ex;
    int x0, cnt;
    expq.delete();
    for (int yy = 0; yy <= H; yy++) begin
      for (int xx = 0; xx <= W; xx++) begin
        ex.r1 = pix_at(xx, yy);
        ex.r2 = pix_at(xx - 1, yy);
        ex.b  = pix_at(xx, yy - 1);
        ex.a  = pix_at(xx - 1, yy - 1);
        ex.x  = XB'(xx);
        ex.y  = YB'(yy);
        ex.eol = (xx == W);
        ex.eof = (xx == W) && (yy == H);
        if (ex.r1) begin
          x0 = xx;
          while (x0 > 0 && pix_at(x0 - 1, yy)) x0--;
          cnt = xx - x0 + 1;
          if (cnt > 7) cnt = 7;
          ex.d = {XB'(x0), XB'(xx), YB'(yy), YB'(yy)};
          ex.e = EB'(cnt);
        end else begin
          ex.d = INIT;
          ex.e = '0;
        end
        expq.push_back(ex);
      end
    end
    n_dv = 0; n_eol = 0; n_eof = 0;
  endtask

  function automatic exp_t reset_vals();
    exp_t r;
    r = '0;
    r.d = INIT;
    return r;
  endfunction

  always @(posedge clk) begin
    exp_t ex, act;
    #1;
    if (rst_n) begin
      act = '{a: A, b: B, r1: r1, r2: r2, eol: eol, eof: eof, x: x, y: y, d: d, e: e};
      if (datavalid) begin
        n_dv++;
        if (eol) n_eol++;
        if (eof) n_eof++;
        if (x <= W && y <= H) begin
          cap_d[y][x] = d; cap_e[y][x] = e; cap_a[y][x] = A; cap_b[y][x] = B;
          cap_r1[y][x] = r1; cap_r2[y][x] = r2; cap_eol[y][x] = eol; cap_eof[y][x] = eof;
        end
        if (expq.size() == 0) begin
          check("unexpected_output", 64'(act), 64'(last));
          check("extra_datavalid", 64'(1), 64'(0));
        end else begin
          ex = expq.pop_front();
          check("stream", 64'(act), 64'(ex));
          last = ex;
        end
      end else begin
        check("hold", 64'(act), 64'(last));
      end
    end
  end

  task automatic send_frame(input bit gaps, input int npix);
    int idx = 0;
    int guard = 0;
    while (idx < npix && guard < 3000) begin
      @(negedge clk);
      guard++;
      pix_valid = gaps ? ($urandom_range(1, 0) == 1) : 1'b1;
      pix = img[idx / W][idx % W];
      if (pix_valid && pix_ready) idx++;
    end
    check("send_timeout", 64'(idx), 64'(npix));
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && expq.size() != 0; i++) @(negedge clk);
    check("drain_timeout", 64'(expq.size()), 64'(0));
    repeat (3) @(negedge clk);
  endtask

  initial begin
    last = reset_vals();
    repeat (3) @(negedge clk);
    check("rst_pix_ready", 64'(pix_ready), 64'(1));
    check("rst_datavalid", 64'(datavalid), 64'(0));
    check("rst_d", 64'(d), 64'(INIT));
    rst_n = 1'b1;

    // All-zero frame: 4 rows of 9 plus a 9-column flush row.
    set_img(8'b0, 8'b0, 8'b0, 8'b0);
    build_exp();
    send_frame(1'b0, W * H);
    drain();
    check("f1_dv_count", 64'(n_dv), 64'(45));
    check("f1_eol_count", 64'(n_eol), 64'(5));
    check("f1_eof_count", 64'(n_eof), 64'(1));

    set_img(8'b00111000, 8'b00111000, 8'b01010101, 8'b11111111);
    build_exp();
    send_frame(1'b0, W * H);
    drain();
    check("f2_dv_count", 64'(n_dv), 64'(45));
    check("lit_r1r2_2_0", 64'({cap_r1[0][2], cap_r2[0][2]}), 64'(2'b10));
    check("lit_d_2_0", 64'(cap_d[0][2]), 64'({4'd2, 4'd2, 3'd0, 3'd0}));
    check("lit_e_2_0", 64'(cap_e[0][2]), 64'(1));
    check("lit_d_4_0", 64'(cap_d[0][4]), 64'({4'd2, 4'd4, 3'd0, 3'd0}));
    check("lit_e_4_0", 64'(cap_e[0][4]), 64'(3));
    check("lit_r1r2_5_0", 64'({cap_r1[0][5], cap_r2[0][5]}), 64'(2'b01));
    check("lit_d_5_0", 64'(cap_d[0][5]), 64'(INIT));
    check("lit_ab_2_1", 64'({cap_a[1][2], cap_b[1][2]}), 64'(2'b01));
    check("lit_ab_3_1", 64'({cap_a[1][3], cap_b[1][3]}), 64'(2'b11));
    check("lit_abr1_5_1", 64'({cap_a[1][5], cap_b[1][5], cap_r1[1][5]}), 64'(3'b100));
    check("lit_colf_8_3", 64'({cap_r1[3][8], cap_r2[3][8], cap_eol[3][8]}), 64'(3'b011));
    check("lit_e_5_3", 64'(cap_e[3][5]), 64'(6));
    check("lit_e_sat_7_3", 64'(cap_e[3][7]), 64'(7));
    check("lit_d_7_3", 64'(cap_d[3][7]), 64'({4'd0, 4'd7, 3'd3, 3'd3}));
    for (int i = 0; i < W; i++) check("lit_frmf_b", 64'(cap_b[4][i]), 64'(1));
    check("lit_frmf_end", 64'({cap_a[4][8], cap_b[4][8], cap_eof[4][8]}), 64'(3'b101));

    // Same frame with random input gaps: identical stream, holds in between.
    build_exp();
    send_frame(1'b1, W * H);
    drain();
    check("f3_dv_count", 64'(n_dv), 64'(45));

    // Reset part-way through row 2, with ones left in the line buffer.
    set_img(8'b11111111, 8'b10011001, 8'b11111111, 8'b00000000);
    build_exp();
    send_frame(1'b0, 2 * W + 5);
    repeat (3) @(negedge clk);
    check("pre_reset_left", 64'(expq.size()), 64'(45 - 23));
    rst_n = 1'b0;
    expq.delete();
    last = reset_vals();
    repeat (2) @(negedge clk);
    check("mid_rst_xy", 64'({x, y}), 64'(0));
    check("mid_rst_d", 64'(d), 64'(INIT));
    check("mid_rst_ready", 64'(pix_ready), 64'(1));
    rst_n = 1'b1;
    set_img(8'b01100110, 8'b11000011, 8'b00011000, 8'b10101010);
    build_exp();
    send_frame(1'b0, W * H);
    drain();
    check("f4_dv_count", 64'(n_dv), 64'(45));
    check("lit_after_rst_0_0", 64'({cap_a[0][0], cap_b[0][0], cap_r1[0][0]}), 64'(3'b000));
    check("lit_after_rst_d", 64'(cap_d[0][0]), 64'(INIT));
    check("lit_after_rst_b_1_0", 64'(cap_b[0][1]), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
